// File: rtl/flb_band_cal_ctrl.sv
// Band-calibration sequencer for the FLB sync path: steps band until the averaged dlf_out is centred.
// Optional continuous tracking after lock is enabled by defining FLB_CAL_TRACK_EN.
module flb_band_cal_ctrl #(
  parameter int DLF_W     = 16,
  parameter int BAND_W    = 8,
  parameter int AVG_LOG2  = 4,
  parameter int CENTER    = 32768,
  parameter int THR       = 2048,
  parameter int MAX_STEPS = 64
) (
  input  logic              ref_clk,
  input  logic              ref_rst_n,
  input  logic              cal_start,
  input  logic              cal_abort,
  input  logic [BAND_W-1:0] csr_band_init,
  input  logic [7:0]        csr_settle_cyc,
  input  logic [DLF_W-1:0]  dlf_out,
  output logic [BAND_W-1:0] band,
  output logic              csr_sync_en,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_err,
  output logic [7:0]        cal_steps,
  output logic [2:0]        cal_state
);

  localparam int ACC_W = DLF_W + AVG_LOG2;
  localparam int CMP_W = DLF_W + 2;

  // Window bounds, clamped at zero so a small CENTER cannot wrap the lower limit.
  localparam int LO1_I = (CENTER > THR) ? (CENTER - THR) : 0;
  localparam int HI1_I = CENTER + THR;
  localparam int LO2_I = (CENTER > 2 * THR) ? (CENTER - 2 * THR) : 0;
  localparam int HI2_I = CENTER + 2 * THR;

  localparam logic [CMP_W-1:0] LO1 = CMP_W'(LO1_I);
  localparam logic [CMP_W-1:0] HI1 = CMP_W'(HI1_I);
  localparam logic [CMP_W-1:0] LO2 = CMP_W'(LO2_I);
  localparam logic [CMP_W-1:0] HI2 = CMP_W'(HI2_I);

  localparam logic [7:0]          MAX_STEPS_C = 8'(MAX_STEPS);
  localparam logic [BAND_W-1:0]   BAND_MAX    = {BAND_W{1'b1}};
  localparam logic [AVG_LOG2-1:0] ACNT_LAST   = {AVG_LOG2{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ACCUM  = 3'd3,
    ST_DECIDE = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [BAND_W-1:0]   band_q, band_d;
  logic [7:0]          steps_q, steps_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                trk_q, trk_d;
  logic [7:0]          settle_q, settle_d;
  logic [AVG_LOG2-1:0] acnt_q, acnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;

  logic [DLF_W-1:0]    avg;
  logic [CMP_W-1:0]    avg_x;
  logic [CMP_W-1:0]    win_lo, win_hi;
  logic                above, below;
  logic [7:0]          settle_m1;
  logic                start_ok;

  assign avg       = acc_q[ACC_W-1:AVG_LOG2];
  assign avg_x     = {2'b00, avg};
  // While tracking, the wider window gives hysteresis against re-stepping on noise.
  assign win_lo    = trk_q ? LO2 : LO1;
  assign win_hi    = trk_q ? HI2 : HI1;
  assign above     = avg_x > win_hi;
  assign below     = avg_x < win_lo;
  assign settle_m1 = (csr_settle_cyc == 8'd0) ? 8'd0 : (csr_settle_cyc - 8'd1);
  assign start_ok  = cal_start &&
                     ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                      (state_q == ST_ERR) || trk_q);

  always_ff @(posedge ref_clk or negedge ref_rst_n) begin
    if (!ref_rst_n) begin
      state_q  <= ST_IDLE;
      band_q   <= '0;
      steps_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      trk_q    <= 1'b0;
      settle_q <= '0;
      acnt_q   <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      band_q   <= band_d;
      steps_q  <= steps_d;
      done_q   <= done_d;
      err_q    <= err_d;
      trk_q    <= trk_d;
      settle_q <= settle_d;
      acnt_q   <= acnt_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    band_d   = band_q;
    steps_d  = steps_q;
    done_d   = done_q;
    err_d    = err_q;
    trk_d    = trk_q;
    settle_d = settle_q;
    acnt_d   = acnt_q;
    acc_d    = acc_q;

    if (cal_abort) begin
      state_d = ST_IDLE;
      trk_d   = 1'b0;
    end else if (start_ok) begin
      state_d = ST_LOAD;
      band_d  = csr_band_init;
      steps_d = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      trk_d   = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          settle_d = settle_m1;
          state_d  = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q == 8'd0) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            acnt_d  = '0;
          end else begin
            settle_d = settle_q - 8'd1;
          end
        end
        ST_ACCUM: begin
          acc_d  = acc_q + {{AVG_LOG2{1'b0}}, dlf_out};
          acnt_d = acnt_q + 1'b1;
          if (acnt_q == ACNT_LAST) state_d = ST_DECIDE;
        end
        ST_DECIDE: begin
          if (!above && !below) begin
            if (trk_q) begin
              state_d = ST_ACCUM;
              acc_d   = '0;
              acnt_d  = '0;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else if (steps_q >= MAX_STEPS_C) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            trk_d   = 1'b0;
          end else if (above) begin
            // Band never wraps: a step past the end of the range is an error.
            if (band_q == BAND_MAX) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
              trk_d   = 1'b0;
            end else begin
              band_d  = band_q + 1'b1;
              steps_d = steps_q + 8'd1;
              state_d = ST_LOAD;
            end
          end else begin
            if (band_q == '0) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
              trk_d   = 1'b0;
            end else begin
              band_d  = band_q - 1'b1;
              steps_d = steps_q + 8'd1;
              state_d = ST_LOAD;
            end
          end
        end
        ST_DONE: begin
`ifdef FLB_CAL_TRACK_EN
          state_d = ST_ACCUM;
          acc_d   = '0;
          acnt_d  = '0;
          trk_d   = 1'b1;
`else
          state_d = ST_DONE;
`endif
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign band        = band_q;
  assign csr_sync_en = (state_q != ST_IDLE) && (state_q != ST_LOAD);
  // Tracking re-steps run through the same states but are not reported as busy.
  assign cal_busy    = ((state_q == ST_LOAD) || (state_q == ST_SETTLE) ||
                        (state_q == ST_ACCUM) || (state_q == ST_DECIDE)) && !trk_q;
  assign cal_done    = done_q;
  assign cal_err     = err_q;
  assign cal_steps   = steps_q;
  assign cal_state   = state_q;

endmodule
